bimodal_branch_predictor: RTL and testbench
===========================================

// Module: bimodal_branch_predictor
// PURPOSE
//   Bimodal (2-bit saturating counter) branch predictor for the LC-3b pipeline, used by fetch.
//   A table of 2^num_addr_bits counters is indexed by PC bits [num_addr_bits:1].
//   Fetch reads a prediction for the current PC. The resolving stage then trains
//   the counter of the latched in-flight branch with taken/not_taken.
//   Only one branch is tracked in flight at a time.
// PARAMETERS
//   num_addr_bits  4  index width; legal 3..6 (8..64 counters); any other value = static not-taken
// PORTS
//   clk                   in   1   single clock, all state updates on posedge
//   rst                   in   1   reset, synchronous, active-high
//   mem_address           in   16  fetch PC (lc3b_word)
//   br_instruction        in   1   fetched instruction is a conditional branch
//   taken                 in   1   in-flight branch resolved taken (1-cycle pulse)
//   not_taken             in   1   in-flight branch resolved not taken (1-cycle pulse)
//   prediction            out  1   prediction for mem_address (combinational)
//   prediction_sync       out  1   prediction for latched in-flight branch address
//   branch_in_flight_out  out  1   a branch is latched and awaiting resolution
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//     - all counters go to 2'b01 (weakly not-taken)
//     - address register goes to 16'h0000 and in_flight goes to 0
//     - so prediction, prediction_sync and branch_in_flight_out read 0 after reset
//   Index:
//     - live_idx = mem_address[num_addr_bits:1]
//     - held_idx = addr_q[num_addr_bits:1]
//     - bit 0 is ignored because PCs are word aligned
//   Outputs:
//     - prediction = counter[live_idx][1]; combinational, zero latency
//     - prediction_sync = counter[held_idx][1]
//   Address register addr_q:
//     - loads mem_address at posedge when br_instruction & ~in_flight & ~rst
//     - otherwise holds its value
//   in_flight_next, in priority order:
//     - rst -> 0
//     - else (taken|not_taken) -> 0
//     - else (br_instruction & ~in_flight) -> 1
//     - else hold
//   branch_in_flight_out = in_flight, i.e. registered, 1 cycle after the load.
//   Counter update: only counter[held_idx] updates, all others hold.
//     - taken & ~not_taken: increment, saturating at 2'b11
//     - not_taken & ~taken: decrement, saturating at 2'b00
//     - both asserted, or neither: hold; in_flight still clears
//   Training is always applied to held_idx, even if in_flight=0. The driver must only pulse
//   taken/not_taken for a latched branch.
//   Simultaneous br_instruction with resolution while in_flight=1: the resolution clears
//   in_flight and addr_q does not load. The new branch is not latched that cycle.
//   Updates are visible on prediction/prediction_sync in the cycle after the posedge.
//   Illegal num_addr_bits: no table is built, and prediction = prediction_sync = 0.
//   addr_q and in_flight behave as for a legal parameter value.
//   Counter state encoding is 00 SNT, 01 WNT, 10 WT, 11 ST; the prediction is the MSB.
// STRUCTURE
//   lc3b_types package provides lc3b_word (16-bit). Add a 2-bit typedef bp_counter_t and the
//   constant BP_CNT_RESET = 2'b01 to the package.
//   Sub-module bp_sat_counter: clk, rst, inc, dec, output 2-bit state and pred.
//   Instantiate it 2^num_addr_bits times in a generate loop. inc/dec are gated by a one-hot
//   decode of held_idx, inline in this block.
//   addr_q is a plain 16-bit flop with load enable and sync reset, inline in this block.
// TESTING
//   1. Reset, then sweep mem_address over all 16 indices (N=4)
//      -> prediction=0 everywhere; in_flight=0.
//   2. PC=16'h0006 with br_instruction=1 for 1 cycle -> branch_in_flight_out=1 next cycle.
//      Then pulse taken -> in_flight=0, and prediction at 16'h0006 becomes 1 (counter 01->10).
//   3. Train idx 3 with taken x4, then not_taken x1 -> counter 11->10, prediction stays 1.
//      Then not_taken x2 -> counter 00, and a further not_taken stays at 00.
//   4. Hold in_flight=1 and present a new branch at 16'h0010 -> addr_q unchanged.
//      prediction_sync still tracks the first address.
//   5. Assert taken and not_taken together -> counter unchanged, in_flight cleared.
//      Assert rst mid-flight -> all counters back to 01, in_flight=0.
//   6. Rerun case 2 at N=3 and N=6; check aliasing PCs 16'h0002 vs 16'h0012 at N=3.
//      At N=7 both predictions stay 0 after taken.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b shared types and branch predictor constants
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Counter encoding: 00 strongly not-taken .. 11 strongly taken; MSB is the prediction.
    typedef logic [1:0] bp_counter_t;

    localparam bp_counter_t BP_CNT_RESET = 2'b01;
    localparam bp_counter_t BP_CNT_MAX   = 2'b11;
    localparam bp_counter_t BP_CNT_MIN   = 2'b00;

    localparam int BP_MIN_ADDR_BITS = 3;
    localparam int BP_MAX_ADDR_BITS = 6;

    function automatic bit bp_legal_addr_bits(input int n);
        return (n >= BP_MIN_ADDR_BITS) && (n <= BP_MAX_ADDR_BITS);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - 2-bit saturating counter for the bimodal predictor
module bp_sat_counter
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        dec,
    output bp_counter_t state,
    output logic        pred
);

    // Simultaneous inc and dec cancel out and the counter holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BP_CNT_RESET;
        end else if (inc && !dec && (state != BP_CNT_MAX)) begin
            state <= state + 2'b01;
        end else if (dec && !inc && (state != BP_CNT_MIN)) begin
            state <= state - 2'b01;
        end
    end

    assign pred = state[1];

endmodule

// File: rtl/bimodal_branch_predictor.sv
// rtl/bimodal_branch_predictor.sv - bimodal branch predictor tracking one in-flight branch
module bimodal_branch_predictor
    import lc3b_types::*;
#(
    parameter int num_addr_bits = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_address,
    input  logic        br_instruction,
    input  logic        taken,
    input  logic        not_taken,
    output logic        prediction,
    output logic        prediction_sync,
    output logic        branch_in_flight_out
);

    localparam bit LEGAL = bp_legal_addr_bits(num_addr_bits);

    lc3b_word addr_q;
    logic     in_flight;
    logic     load_branch;

    assign load_branch = br_instruction & ~in_flight;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 16'h0000;
        end else if (load_branch) begin
            addr_q <= mem_address;
        end
    end

    // A resolution wins over a newly fetched branch in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= 1'b0;
        end else if (taken | not_taken) begin
            in_flight <= 1'b0;
        end else if (load_branch) begin
            in_flight <= 1'b1;
        end
    end

    assign branch_in_flight_out = in_flight;

    generate
        if (LEGAL) begin : g_table
            localparam int NUM_ENTRIES = 1 << num_addr_bits;

            logic [num_addr_bits-1:0] live_idx;
            logic [num_addr_bits-1:0] held_idx;
            logic [NUM_ENTRIES-1:0]   held_sel;
            logic [NUM_ENTRIES-1:0]   pred_vec;
            bp_counter_t              cnt_state [NUM_ENTRIES];
            logic                     unused_addr_bits;

            assign live_idx = mem_address[num_addr_bits:1];
            assign held_idx = addr_q[num_addr_bits:1];

            // Bit 0 and the bits above the index never select a counter.
            assign unused_addr_bits = ^{addr_q[15:num_addr_bits+1], addr_q[0]};

            always_comb begin
                held_sel           = '0;
                held_sel[held_idx] = 1'b1;
            end

            for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cnt
                bp_sat_counter u_cnt (
                    .clk   (clk),
                    .rst   (rst),
                    .inc   (held_sel[i] & taken),
                    .dec   (held_sel[i] & not_taken),
                    .state (cnt_state[i]),
                    .pred  (pred_vec[i])
                );
            end

            assign prediction      = pred_vec[live_idx];
            assign prediction_sync = cnt_state[held_idx][1];
        end else begin : g_static
            logic unused_addr_bits;

            assign unused_addr_bits = ^addr_q;
            assign prediction       = 1'b0;
            assign prediction_sync  = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// tb/tb_bimodal_branch_predictor.sv - randomized bench against a reference predictor model
module tb_bimodal_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_address = 16'h0000;
    logic        br_instruction = 1'b0;
    logic        taken = 1'b0;
    logic        not_taken = 1'b0;

    logic pred  [4];
    logic psync [4];
    logic bif   [4];

    int nb [4] = '{3, 4, 6, 7};

    int tests = 0;
    int fails = 0;

    int          mcnt [4][64];
    logic [15:0] m_addr;
    logic        m_inflight;

    always #5 clk = ~clk;

    bimodal_branch_predictor #(.num_addr_bits(3)) u_n3 (
        .clk(clk), .rst(rst), .mem_address(mem_address), .br_instruction(br_instruction),
        .taken(taken), .not_taken(not_taken), .prediction(pred[0]),
        .prediction_sync(psync[0]), .branch_in_flight_out(bif[0]));

    bimodal_branch_predictor #(.num_addr_bits(4)) u_n4 (
        .clk(clk), .rst(rst), .mem_address(mem_address), .br_instruction(br_instruction),
        .taken(taken), .not_taken(not_taken), .prediction(pred[1]),
        .prediction_sync(psync[1]), .branch_in_flight_out(bif[1]));

    bimodal_branch_predictor #(.num_addr_bits(6)) u_n6 (
        .clk(clk), .rst(rst), .mem_address(mem_address), .br_instruction(br_instruction),
        .taken(taken), .not_taken(not_taken), .prediction(pred[2]),
        .prediction_sync(psync[2]), .branch_in_flight_out(bif[2]));

    bimodal_branch_predictor #(.num_addr_bits(7)) u_n7 (
        .clk(clk), .rst(rst), .mem_address(mem_address), .br_instruction(br_instruction),
        .taken(taken), .not_taken(not_taken), .prediction(pred[3]),
        .prediction_sync(psync[3]), .branch_in_flight_out(bif[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_idx(input int k, input logic [15:0] a);
        return (int'(a) / 2) % (1 << nb[k]);
    endfunction

    function automatic logic model_pred(input int k, input logic [15:0] a);
        if (nb[k] < 3 || nb[k] > 6) return 1'b0;
        return mcnt[k][model_idx(k, a)] >= 2;
    endfunction

    task automatic model_step(input logic [15:0] pc, input logic b, input logic t,
                              input logic nt, input logic r);
        if (r) begin
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 64; i++) mcnt[k][i] = 1;
            m_addr     = 16'h0000;
            m_inflight = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = model_idx(k, m_addr);
                if (t && !nt && mcnt[k][i] < 3) mcnt[k][i] = mcnt[k][i] + 1;
                if (nt && !t && mcnt[k][i] > 0) mcnt[k][i] = mcnt[k][i] - 1;
            end
            if (b && !m_inflight) m_addr = pc;
            if (t || nt) m_inflight = 1'b0;
            else if (b) m_inflight = 1'b1;
        end
    endtask

    task automatic verify(input string ph);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s pred n%0d pc=%h", ph, nb[k], mem_address),
                  32'(pred[k]), 32'(model_pred(k, mem_address)));
            check($sformatf("%s sync n%0d", ph, nb[k]),
                  32'(psync[k]), 32'(model_pred(k, m_addr)));
            check($sformatf("%s inflight n%0d", ph, nb[k]),
                  32'(bif[k]), 32'(m_inflight));
        end
    endtask

    task automatic cyc(input logic [15:0] pc, input logic b, input logic t,
                       input logic nt, input logic r, input string ph);
        mem_address    = pc;
        br_instruction = b;
        taken          = t;
        not_taken      = nt;
        rst            = r;
        @(posedge clk);
        model_step(pc, b, t, nt, r);
        #1;
        verify(ph);
    endtask

    task automatic peek(input logic [15:0] pc, input string ph);
        mem_address    = pc;
        br_instruction = 1'b0;
        taken          = 1'b0;
        not_taken      = 1'b0;
        rst            = 1'b0;
        #1;
        verify(ph);
    endtask

    task automatic resolve(input logic [15:0] pc, input logic t, input string ph);
        cyc(pc, 1'b1, 1'b0, 1'b0, 1'b0, ph);
        cyc(pc, 1'b0, t, ~t, 1'b0, ph);
    endtask

    initial begin
        m_addr     = 16'h0000;
        m_inflight = 1'b0;

        cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
        for (int i = 0; i < 16; i++) begin
            peek(16'(i * 2), "sweep");
            check("sweep_const", 32'(pred[1]), 32'd0);
        end
        check("reset_inflight", 32'(bif[1]), 32'd0);

        cyc(16'h0006, 1'b1, 1'b0, 1'b0, 1'b0, "t2_latch");
        check("t2_inflight_set", 32'(bif[1]), 32'd1);
        cyc(16'h0006, 1'b0, 1'b1, 1'b0, 1'b0, "t2_taken");
        check("t2_inflight_clr", 32'(bif[1]), 32'd0);
        check("t2_pred_n4", 32'(pred[1]), 32'd1);
        check("t2_pred_n7", 32'(pred[3]), 32'd0);

        for (int i = 0; i < 4; i++) resolve(16'h0006, 1'b1, "t3_up");
        resolve(16'h0006, 1'b0, "t3_dn1");
        check("t3_after_one_nt", 32'(pred[1]), 32'd1);
        resolve(16'h0006, 1'b0, "t3_dn2");
        resolve(16'h0006, 1'b0, "t3_dn3");
        check("t3_reach_snt", 32'(pred[1]), 32'd0);
        resolve(16'h0006, 1'b0, "t3_floor");
        resolve(16'h0006, 1'b1, "t3_floor_up");
        check("t3_floor_held", 32'(pred[1]), 32'd0);

        cyc(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, "t4_latch");
        cyc(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, "t4_second");
        cyc(16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, "t4_resolve");
        peek(16'h0004, "t4_first");
        check("t4_first_trained", 32'(pred[1]), 32'd1);
        peek(16'h0010, "t4_other");
        check("t4_other_untouched", 32'(pred[1]), 32'd0);

        cyc(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, "t5_latch");
        cyc(16'h0004, 1'b0, 1'b1, 1'b1, 1'b0, "t5_both");
        check("t5_both_clears", 32'(bif[1]), 32'd0);
        check("t5_both_holds", 32'(pred[1]), 32'd1);
        cyc(16'h0006, 1'b1, 1'b0, 1'b0, 1'b0, "t5_latch2");
        cyc(16'h0006, 1'b0, 1'b0, 1'b0, 1'b1, "t5_rst");
        check("t5_rst_inflight", 32'(bif[1]), 32'd0);
        for (int i = 0; i < 64; i++) peek(16'(i * 2), "t5_sweep");

        resolve(16'h0002, 1'b1, "t6_train");
        peek(16'h0012, "t6_alias");
        check("t6_alias_n3", 32'(pred[0]), 32'd1);
        check("t6_noalias_n4", 32'(pred[1]), 32'd0);
        check("t6_static_n7", 32'(pred[3]), 32'd0);
        peek(16'h0002, "t6_direct");
        check("t6_direct_n6", 32'(pred[2]), 32'd1);
        check("t6_direct_n7", 32'(pred[3]), 32'd0);

        for (int n = 0; n < 600; n++) begin
            logic [15:0] pc;
            logic        b, t, nt, r;
            int          sel;
            pc  = 16'($urandom_range(0, 16'hffff));
            b   = ($urandom_range(0, 2) == 0);
            t   = 1'b0;
            nt  = 1'b0;
            sel = $urandom_range(0, 9);
            if (m_inflight && sel < 6) begin
                t  = (sel < 3);
                nt = (sel >= 2 && sel < 5);
            end
            r = ($urandom_range(0, 199) == 0);
            cyc(pc, b, t, nt, r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
